// File: rtl/sram_async_ctrl_if.sv
// Request-side bus between a clocked core and sram_async_ctrl: a single-word
// req/ready handshake plus the read-data and completion strobes.
interface sram_async_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rd_valid;
  logic                  wr_done;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, rd_valid, wr_done
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, rd_valid, wr_done
  );
endinterface

// File: rtl/sram_async_ctrl.sv
// Sequences single-word reads and writes onto an asynchronous SRAM bus with
// setup, pulse, hold and access times programmable in clock cycles.
module sram_async_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_WAIT    = 2,
  parameter int WR_SETUP   = 1,
  parameter int WR_PULSE   = 2,
  parameter int WR_HOLD    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_async_ctrl_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_ce1n,
  output logic                  sram_ce2,
  output logic                  sram_oen,
  output logic                  sram_wen,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_doe,
  input  logic [DATA_WIDTH-1:0] sram_din
);

  localparam int MAX_RW  = (RD_WAIT  > WR_SETUP) ? RD_WAIT  : WR_SETUP;
  localparam int MAX_PH  = (WR_PULSE > WR_HOLD)  ? WR_PULSE : WR_HOLD;
  localparam int CNT_MAX = (MAX_RW   > MAX_PH)   ? MAX_RW   : MAX_PH;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WS   = 3'd2;
  localparam logic [2:0] S_WP   = 3'd3;
  localparam logic [2:0] S_WH   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  if (RD_WAIT < 1 || WR_SETUP < 1 || WR_PULSE < 1 || WR_HOLD < 1) begin : g_bad_timing
    $error("sram_async_ctrl: RD_WAIT, WR_SETUP, WR_PULSE and WR_HOLD must all be >= 1");
  end

  logic [2:0]            state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  we_q,        we_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0] sram_dout_q, sram_dout_d;
  logic [DATA_WIDTH-1:0] rdata_q,     rdata_d;
  logic                  ce1n_q,      ce1n_d;
  logic                  ce2_q,       ce2_d;
  logic                  oen_q,       oen_d;
  logic                  wen_q,       wen_d;
  logic                  doe_q,       doe_d;
  logic                  rd_valid_q,  rd_valid_d;
  logic                  wr_done_q,   wr_done_d;
  logic                  ce_act;

  assign bus.ready = (state_q == S_IDLE) && !rst;

  // Next state, counter and captured request fields.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    sram_addr_d = sram_addr_q;
    sram_dout_d = sram_dout_q;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req && bus.ready) begin
          we_d        = bus.we;
          sram_addr_d = bus.addr;
          sram_dout_d = bus.wdata;
          if (bus.we) begin
            state_d = S_WS;
            cnt_d   = CNT_W'(WR_SETUP);
          end else begin
            state_d = S_RD;
            cnt_d   = CNT_W'(RD_WAIT);
          end
        end
      end
      S_RD: begin
        if (cnt_q == CNT_ONE) begin
          rdata_d = sram_din;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WS: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_WP;
          cnt_d   = CNT_W'(WR_PULSE);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WP: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_WH;
          cnt_d   = CNT_W'(WR_HOLD);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WH: begin
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus controls are decoded from the next state so that every SRAM pin comes
  // straight from a flop and changes exactly on the state boundary.
  always_comb begin
    ce_act     = (state_d == S_RD) || (state_d == S_WS) ||
                 (state_d == S_WP) || (state_d == S_WH);
    ce1n_d     = !ce_act;
    ce2_d      = ce_act;
    oen_d      = (state_d != S_RD);
    wen_d      = (state_d != S_WP);
    doe_d      = (state_d == S_WS) || (state_d == S_WP) || (state_d == S_WH);
    rd_valid_d = (state_d == S_DONE) && !we_q;
    wr_done_d  = (state_d == S_DONE) &&  we_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      sram_addr_q <= '0;
      sram_dout_q <= '0;
      rdata_q     <= '0;
      ce1n_q      <= 1'b1;
      ce2_q       <= 1'b0;
      oen_q       <= 1'b1;
      wen_q       <= 1'b1;
      doe_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      sram_addr_q <= sram_addr_d;
      sram_dout_q <= sram_dout_d;
      rdata_q     <= rdata_d;
      ce1n_q      <= ce1n_d;
      ce2_q       <= ce2_d;
      oen_q       <= oen_d;
      wen_q       <= wen_d;
      doe_q       <= doe_d;
      rd_valid_q  <= rd_valid_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign sram_addr    = sram_addr_q;
  assign sram_dout    = sram_dout_q;
  assign sram_ce1n    = ce1n_q;
  assign sram_ce2     = ce2_q;
  assign sram_oen     = oen_q;
  assign sram_wen     = wen_q;
  assign sram_doe     = doe_q;
  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_done  = wr_done_q;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Bench for sram_async_ctrl: directed cycle-exact checks on a default-timing
// instance, and a random read/write soak on a RD_WAIT=4, WR_PULSE=1 instance.
module tb_sram_async_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- instance A: default timing ----------------
  sram_async_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) busa ();
  logic [9:0] a_addr;
  logic       a_ce1n, a_ce2, a_oen, a_wen, a_doe;
  logic [7:0] a_dout, a_din;
  logic [7:0] mem_a [0:1023];

  sram_async_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(10),
    .RD_WAIT(2), .WR_SETUP(1), .WR_PULSE(2), .WR_HOLD(1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(busa),
    .sram_addr(a_addr), .sram_ce1n(a_ce1n), .sram_ce2(a_ce2),
    .sram_oen(a_oen), .sram_wen(a_wen), .sram_dout(a_dout),
    .sram_doe(a_doe), .sram_din(a_din)
  );

  assign a_din = (!a_ce1n && a_ce2 && !a_oen) ? mem_a[a_addr] : 8'h00;
  always @(posedge clk) if (!a_ce1n && a_ce2 && !a_wen && a_doe) mem_a[a_addr] <= a_dout;

  // ---------------- instance B: RD_WAIT=4, WR_PULSE=1 ----------------
  sram_async_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) busb ();
  logic [9:0] b_addr;
  logic       b_ce1n, b_ce2, b_oen, b_wen, b_doe;
  logic [7:0] b_dout, b_din;
  logic [7:0] mem_b [0:1023];
  logic [7:0] ref_mem [0:15];

  sram_async_ctrl #(
    .DATA_WIDTH(8), .ADDR_WIDTH(10),
    .RD_WAIT(4), .WR_SETUP(1), .WR_PULSE(1), .WR_HOLD(1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(busb),
    .sram_addr(b_addr), .sram_ce1n(b_ce1n), .sram_ce2(b_ce2),
    .sram_oen(b_oen), .sram_wen(b_wen), .sram_dout(b_dout),
    .sram_doe(b_doe), .sram_din(b_din)
  );

  assign b_din = (!b_ce1n && b_ce2 && !b_oen) ? mem_b[b_addr] : 8'h00;
  always @(posedge clk) if (!b_ce1n && b_ce2 && !b_wen && b_doe) mem_b[b_addr] <= b_dout;

  // ---------------- bus invariant monitor ----------------
  logic       prev_ce_a = 1'b0, prev_ce_b = 1'b0;
  logic [9:0] prev_addr_a, prev_addr_b;
  logic [7:0] prev_rdata_a, prev_rdata_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (!a_oen && !a_wen) viol++;
      if (a_doe && !a_oen) viol++;
      if (a_ce1n == a_ce2) viol++;
      if (!a_ce1n && prev_ce_a && a_addr != prev_addr_a) viol++;
      if (!busa.rd_valid && busa.rdata != prev_rdata_a) viol++;
      if (busa.rd_valid && busa.wr_done) viol++;
      if (!b_oen && !b_wen) viol++;
      if (b_doe && !b_oen) viol++;
      if (b_ce1n == b_ce2) viol++;
      if (!b_ce1n && prev_ce_b && b_addr != prev_addr_b) viol++;
      if (!busb.rd_valid && busb.rdata != prev_rdata_b) viol++;
      if (busb.rd_valid && busb.wr_done) viol++;
    end
    prev_ce_a    = !a_ce1n;
    prev_ce_b    = !b_ce1n;
    prev_addr_a  = a_addr;
    prev_addr_b  = b_addr;
    prev_rdata_a = busa.rdata;
    prev_rdata_b = busb.rdata;
  end

  // ---------------- per-cycle recording for instance A ----------------
  // Bit c of each mask is set if the condition held in cycle c after acceptance.
  logic [15:0] m_wen, m_oen, m_doe, m_ce, m_rdv, m_wrd, m_rdy, m_acc;
  logic [7:0]  cap_rdata;

  task automatic a_accept(input logic w, input logic [9:0] ad, input logic [7:0] d);
    int t = 0;
    busa.req = 1'b1; busa.we = w; busa.addr = ad; busa.wdata = d;
    @(negedge clk);
    while (!busa.ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("a_accept", busa.ready, 1'b1);
  endtask

  task automatic a_record(input int n);
    m_wen = '0; m_oen = '0; m_doe = '0; m_ce = '0;
    m_rdv = '0; m_wrd = '0; m_rdy = '0; m_acc = '0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      m_wen[c] = !a_wen;
      m_oen[c] = !a_oen;
      m_doe[c] = a_doe;
      m_ce[c]  = !a_ce1n;
      m_rdv[c] = busa.rd_valid;
      m_wrd[c] = busa.wr_done;
      m_rdy[c] = busa.ready;
      if (busa.rd_valid) cap_rdata = busa.rdata;
      if (busa.req && busa.ready) begin
        m_acc[c] = 1'b1;
        @(posedge clk);
        #1 busa.req = 1'b0;
      end
    end
  endtask

  // ---------------- single op on instance B ----------------
  task automatic b_op(input logic w, input logic [9:0] ad, input logic [7:0] d,
                      output logic [7:0] rd);
    int t = 0;
    int lat;
    busb.req = 1'b1; busb.we = w; busb.addr = ad; busb.wdata = d;
    @(negedge clk);
    while (!busb.ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("b_accept", busb.ready, 1'b1);
    @(posedge clk);
    #1 busb.req = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!(busb.rd_valid || busb.wr_done) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check(w ? "b_wr_latency" : "b_rd_latency", lat, w ? 4 : 5);
    check(w ? "b_wr_done" : "b_rd_valid", w ? busb.wr_done : busb.rd_valid, 1'b1);
    rd = busb.rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [3:0] ra;
    logic [7:0] rv;
    logic       rw;
    logic       wrd_seen;

    rst = 1'b1;
    busa.req = 1'b0; busa.we = 1'b0; busa.addr = '0; busa.wdata = '0;
    busb.req = 1'b0; busb.we = 1'b0; busb.addr = '0; busb.wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready",    busa.ready,    1'b1);
    check("rst_ce1n",     a_ce1n,        1'b1);
    check("rst_ce2",      a_ce2,         1'b0);
    check("rst_oen",      a_oen,         1'b1);
    check("rst_wen",      a_wen,         1'b1);
    check("rst_doe",      a_doe,         1'b0);
    check("rst_rd_valid", busa.rd_valid, 1'b0);
    check("rst_wr_done",  busa.wr_done,  1'b0);
    check("rst_rdata",    busa.rdata,    8'h00);
    check("rst_addr",     a_addr,        10'h000);
    check("rst_dout",     a_dout,        8'h00);

    // Write 0x155 <= 0xA5
    a_accept(1'b1, 10'h155, 8'hA5);
    @(posedge clk);
    #1 busa.req = 1'b0;
    a_record(6);
    check("wr_wen_low",  m_wen, 16'h000C);
    check("wr_doe",      m_doe, 16'h001E);
    check("wr_ce",       m_ce,  16'h001E);
    check("wr_oen",      m_oen, 16'h0000);
    check("wr_done_cyc", m_wrd, 16'h0020);
    check("wr_ready",    m_rdy, 16'h0040);
    check("wr_mem",      mem_a[10'h155], 8'hA5);

    // Read 0x155
    a_accept(1'b0, 10'h155, 8'h00);
    @(posedge clk);
    #1 busa.req = 1'b0;
    a_record(4);
    check("rd_oen_low", m_oen, 16'h0006);
    check("rd_wen",     m_wen, 16'h0000);
    check("rd_doe",     m_doe, 16'h0000);
    check("rd_valid",   m_rdv, 16'h0008);
    check("rd_ready",   m_rdy, 16'h0010);
    check("rd_data",    cap_rdata, 8'hA5);

    // Back-to-back: write 0x000 <= 0x3C, then read 0x000 with req held high
    a_accept(1'b1, 10'h000, 8'h3C);
    @(posedge clk);
    #1 busa.we = 1'b0;
    a_record(10);
    check("b2b_accept",  m_acc, 16'h0040);
    check("b2b_wr_done", m_wrd, 16'h0020);
    check("b2b_rd_vld",  m_rdv, 16'h0200);
    check("b2b_ce",      m_ce,  16'h019E);
    check("b2b_oen",     m_oen, 16'h0180);
    check("b2b_wen",     m_wen, 16'h000C);
    check("b2b_rdata",   cap_rdata, 8'h3C);

    // Reset during the write pulse aborts the cycle
    a_accept(1'b1, 10'h2AA, 8'h5A);
    @(posedge clk);
    #1 busa.req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_wen_pre", a_wen, 1'b0);
    wrd_seen = busa.wr_done;
    @(negedge clk);
    check("abort_wen",  a_wen,  1'b1);
    check("abort_ce1n", a_ce1n, 1'b1);
    check("abort_ce2",  a_ce2,  1'b0);
    check("abort_doe",  a_doe,  1'b0);
    wrd_seen = wrd_seen | busa.wr_done;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", busa.ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wrd_seen = wrd_seen | busa.wr_done;
      @(negedge clk);
    end
    check("abort_no_wr_done", wrd_seen, 1'b0);

    // Random soak on instance B against a reference array
    for (int i = 0; i < 16; i++) begin
      rv = 8'($urandom_range(0, 255));
      b_op(1'b1, 10'(i), rv, rd);
      ref_mem[i] = rv;
    end
    for (int i = 0; i < 984; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = 4'($urandom_range(0, 15));
      rv = 8'($urandom_range(0, 255));
      b_op(rw, {6'd0, ra}, rv, rd);
      if (rw) ref_mem[ra] = rv;
      else    check("b_rdata", rd, ref_mem[ra]);
    end

    @(negedge clk);
    check("invariants", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
